// File: rtl/regfile_mp_if.sv
// Request/response bundle between the datapath and the MIPS register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_data_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              busy;
    logic              req_drop;

    modport master (
        output rd_valid, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_data_b, rd_data_valid, wr_ack, busy, req_drop
    );

    modport slave (
        input  rd_valid, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
        output rd_data_a, rd_data_b, rd_data_valid, wr_ack, busy, req_drop
    );
endinterface

// File: rtl/regfile_mp.sv
// MIPS register file: two registered read ports, one write port, post-reset
// clear sweep so the array can live in RAM-style storage.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_a_r;
    logic [DATA_W-1:0] rd_data_b_r;
    logic              rd_data_valid_r;
    logic              wr_ack_r;
    logic              busy_r;
    logic              req_drop_r;

    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] val_a_s;
    logic [DATA_W-1:0] val_b_s;

    // r0 wins over forwarding; forwarding wins over the stored entry.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        logic [DATA_W-1:0] value;
        if (R0_ZERO && (addr == {ADDR_W{1'b0}})) begin
            value = {DATA_W{1'b0}};
        end else if (BYPASS && fwd_en && (fwd_addr == addr)) begin
            value = fwd_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Request acceptance: only in READY and not on a reset edge.
    always_comb begin
        wr_fire_s = 1'b0;
        rd_fire_s = 1'b0;
        if (!reset && (state_r == READY)) begin
            wr_fire_s = bus.wr_en;
            rd_fire_s = bus.rd_valid;
        end else begin
            wr_fire_s = 1'b0;
            rd_fire_s = 1'b0;
        end
    end

    // Single storage write port shared by the clear sweep and normal writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == CLEAR) begin
            mem_we_s = 1'b1;
        end else if (wr_fire_s && !(R0_ZERO && (bus.wr_addr == {ADDR_W{1'b0}}))) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.wr_addr;
            mem_wdata_s = bus.wr_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read-port values before registering.
    always_comb begin
        val_a_s = read_value(bus.rd_addr_a, mem_r[bus.rd_addr_a], wr_fire_s, bus.wr_addr, bus.wr_data);
        val_b_s = read_value(bus.rd_addr_b, mem_r[bus.rd_addr_b], wr_fire_s, bus.wr_addr, bus.wr_data);
    end

    // Storage array, kept free of reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Sweep FSM plus all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= CLEAR;
            ptr_r           <= {ADDR_W{1'b0}};
            busy_r          <= 1'b1;
            rd_data_a_r     <= {DATA_W{1'b0}};
            rd_data_b_r     <= {DATA_W{1'b0}};
            rd_data_valid_r <= 1'b0;
            wr_ack_r        <= 1'b0;
            req_drop_r      <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    ptr_r <= ptr_r + ADDR_W'(1);
                    if (ptr_r == {ADDR_W{1'b1}}) begin
                        state_r <= READY;
                        busy_r  <= 1'b0;
                    end
                end
                READY: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= CLEAR;
                    ptr_r   <= {ADDR_W{1'b0}};
                    busy_r  <= 1'b1;
                end
            endcase
            req_drop_r      <= busy_r & (bus.rd_valid | bus.wr_en);
            rd_data_valid_r <= rd_fire_s;
            wr_ack_r        <= wr_fire_s;
            if (rd_fire_s) begin
                rd_data_a_r <= val_a_s;
                rd_data_b_r <= val_b_s;
            end
        end
    end

    assign bus.rd_data_a     = rd_data_a_r;
    assign bus.rd_data_b     = rd_data_b_r;
    assign bus.rd_data_valid = rd_data_valid_r;
    assign bus.wr_ack        = wr_ack_r;
    assign bus.busy          = busy_r;
    assign bus.req_drop      = req_drop_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default register file plus a small 16x8 instance without r0/bypass.
module tb_regfile_mp;
    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   failures;
    int   first;
    int   nz;
    int   nv;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .bus(b0.slave)
    );
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1'b0), .BYPASS(1'b0)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle0();
        b0.rd_valid = 1'b0; b0.rd_addr_a = 5'd0; b0.rd_addr_b = 5'd0;
        b0.wr_en = 1'b0; b0.wr_addr = 5'd0; b0.wr_data = 32'd0;
    endtask

    task automatic idle1();
        b1.rd_valid = 1'b0; b1.rd_addr_a = 3'd0; b1.rd_addr_b = 3'd0;
        b1.wr_en = 1'b0; b1.wr_addr = 3'd0; b1.wr_data = 16'd0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst0 = 1'b1; rst1 = 1'b1;
        idle0(); idle1();
        repeat (3) tick();
        chk("rst_rd_data_a", b0.rd_data_a, 32'd0);
        chk("rst_rd_data_b", b0.rd_data_b, 32'd0);
        chk("rst_rd_valid", {31'd0, b0.rd_data_valid}, 32'd0);
        chk("rst_wr_ack", {31'd0, b0.wr_ack}, 32'd0);
        chk("rst_req_drop", {31'd0, b0.req_drop}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy}, 32'd1);

        // Sweep with a request dropped at sweep cycle 10.
        rst0 = 1'b0; first = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                b0.wr_en = 1'b1; b0.wr_addr = 5'd3; b0.wr_data = 32'hAA;
                b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd3; b0.rd_addr_b = 5'd3;
            end
            tick();
            if (k == 10) begin
                idle0();
                chk("drop_pulse", {31'd0, b0.req_drop}, 32'd1);
                chk("drop_no_ack", {31'd0, b0.wr_ack}, 32'd0);
                chk("drop_no_rdv", {31'd0, b0.rd_data_valid}, 32'd0);
            end
            if (k == 11) chk("drop_once", {31'd0, b0.req_drop}, 32'd0);
            if (first == 0 && b0.busy === 1'b0) first = k;
        end
        chk("sweep_len", first, 32'd32);

        // Every entry reads zero after the sweep.
        nz = 0; nv = 0;
        for (int a = 0; a < 32; a++) begin
            b0.rd_valid = 1'b1; b0.rd_addr_a = a[4:0]; b0.rd_addr_b = 5'(31 - a);
            tick();
            if (b0.rd_data_valid === 1'b1) nv++;
            if (b0.rd_data_a !== 32'd0 || b0.rd_data_b !== 32'd0) nz++;
        end
        idle0();
        tick();
        chk("rdv_falls", {31'd0, b0.rd_data_valid}, 32'd0);
        chk("sweep_zero", nz, 32'd0);
        chk("rdv_pulses", nv, 32'd32);

        // Write r5, then read r5 / r0.
        b0.wr_en = 1'b1; b0.wr_addr = 5'd5; b0.wr_data = 32'hDEADBEEF;
        tick(); idle0();
        chk("wr_ack", {31'd0, b0.wr_ack}, 32'd1);
        tick();
        chk("wr_ack_once", {31'd0, b0.wr_ack}, 32'd0);
        b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd5; b0.rd_addr_b = 5'd0;
        tick(); idle0();
        chk("rd_r5", b0.rd_data_a, 32'hDEADBEEF);
        chk("rd_r0", b0.rd_data_b, 32'd0);
        chk("rd_valid", {31'd0, b0.rd_data_valid}, 32'd1);

        // Same-edge write and read of r7 is forwarded.
        b0.wr_en = 1'b1; b0.wr_addr = 5'd7; b0.wr_data = 32'h12345678;
        b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd7; b0.rd_addr_b = 5'd5;
        tick(); idle0();
        chk("byp_a", b0.rd_data_a, 32'h12345678);
        chk("byp_b", b0.rd_data_b, 32'hDEADBEEF);
        tick();
        chk("hold_a", b0.rd_data_a, 32'h12345678);
        chk("hold_rdv", {31'd0, b0.rd_data_valid}, 32'd0);

        // r0 ignores writes, even when forwarded on the same edge.
        b0.wr_en = 1'b1; b0.wr_addr = 5'd0; b0.wr_data = 32'hFFFFFFFF;
        b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd0; b0.rd_addr_b = 5'd0;
        tick(); idle0();
        chk("r0_ack", {31'd0, b0.wr_ack}, 32'd1);
        chk("r0_byp_a", b0.rd_data_a, 32'd0);
        b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd0; b0.rd_addr_b = 5'd0;
        tick(); idle0();
        chk("r0_a", b0.rd_data_a, 32'd0);
        chk("r0_b", b0.rd_data_b, 32'd0);

        // Reset again, then a one-cycle reset pulse at sweep cycle 20.
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        repeat (20) tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (first == 0 && b0.busy === 1'b0) first = k;
        end
        chk("midrst_len", first, 32'd32);
        b0.rd_valid = 1'b1; b0.rd_addr_a = 5'd5; b0.rd_addr_b = 5'd7;
        tick(); idle0();
        chk("midrst_r5", b0.rd_data_a, 32'd0);
        chk("midrst_r7", b0.rd_data_b, 32'd0);

        // Small instance: 8 entries, 16-bit, no r0 protection, no bypass.
        rst1 = 1'b0; first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (first == 0 && b1.busy === 1'b0) first = k;
        end
        chk("small_sweep", first, 32'd8);
        b1.wr_en = 1'b1; b1.wr_addr = 3'd7; b1.wr_data = 16'hBEEF;
        tick(); idle1();
        chk("small_ack", {31'd0, b1.wr_ack}, 32'd1);
        b1.rd_valid = 1'b1; b1.rd_addr_a = 3'd7; b1.rd_addr_b = 3'd7;
        tick(); idle1();
        chk("small_r7_a", {16'd0, b1.rd_data_a}, 32'h0000BEEF);
        chk("small_r7_b", {16'd0, b1.rd_data_b}, 32'h0000BEEF);
        b1.wr_en = 1'b1; b1.wr_addr = 3'd7; b1.wr_data = 16'h5678;
        b1.rd_valid = 1'b1; b1.rd_addr_a = 3'd7;
        tick(); idle1();
        chk("nobyp_old", {16'd0, b1.rd_data_a}, 32'h0000BEEF);
        b1.rd_valid = 1'b1; b1.rd_addr_a = 3'd7;
        tick(); idle1();
        chk("nobyp_new", {16'd0, b1.rd_data_a}, 32'h00005678);
        b1.wr_en = 1'b1; b1.wr_addr = 3'd0; b1.wr_data = 16'hFFFF;
        tick(); idle1();
        chk("nor0_ack", {31'd0, b1.wr_ack}, 32'd1);
        b1.rd_valid = 1'b1; b1.rd_addr_a = 3'd0; b1.rd_addr_b = 3'd0;
        tick(); idle1();
        chk("nor0_a", {16'd0, b1.rd_data_a}, 32'h0000FFFF);
        chk("nor0_b", {16'd0, b1.rd_data_b}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
